// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision types and constants for the FP datapath
package fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
  localparam logic [31:0] FP_INF   = 32'h7F80_0000;

  // Quotient bits produced: integer bit, 23 fraction bits, guard, round, one spare
  localparam int QBITS = 27;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    DIV,
    RND,
    DONE
  } fpdiv_state_e;

endpackage

// File: rtl/fp_round_norm.sv
// rtl/fp_round_norm.sv - normalise a raw quotient, round to nearest even, clamp exponent range
module fp_round_norm
  import fp_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp_in,
  input  logic [QBITS-1:0]  quot,
  input  logic              rem_nz,
  output logic [31:0]       result,
  output logic              overflow,
  output logic              underflow
);

  logic [23:0]       sig;
  logic              guard_bit;
  logic              round_bit;
  logic              sticky_bit;
  logic              rnd_up;
  logic [24:0]       sig_r;
  logic [22:0]       frac;
  logic signed [9:0] e_norm;
  logic signed [9:0] e_fin;

  // Leading-one alignment, RNE increment, carry renormalise, then range clamp
  always_comb begin
    sig        = '0;
    guard_bit  = 1'b0;
    round_bit  = 1'b0;
    sticky_bit = 1'b0;
    e_norm     = exp_in;
    if (quot[QBITS-1]) begin
      sig        = quot[26:3];
      guard_bit  = quot[2];
      round_bit  = quot[1];
      sticky_bit = quot[0] | rem_nz;
    end else begin
      // a quotient below 1.0 (ma < mb) always has its leading one at bit 25
      sig        = quot[25:2];
      guard_bit  = quot[1];
      round_bit  = quot[0];
      sticky_bit = rem_nz;
      e_norm     = exp_in - 10'sd1;
    end

    rnd_up = guard_bit & (round_bit | sticky_bit | sig[0]);
    sig_r  = {1'b0, sig} + {24'd0, rnd_up};

    if (sig_r[24]) begin
      frac  = sig_r[23:1];
      e_fin = e_norm + 10'sd1;
    end else begin
      frac  = sig_r[22:0];
      e_fin = e_norm;
    end

    overflow  = 1'b0;
    underflow = 1'b0;
    if (e_fin >= 10'sd255) begin
      result   = {sign, FP_INF[30:0]};
      overflow = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      result    = {sign, 31'd0};
      underflow = 1'b1;
    end else begin
      result = {sign, e_fin[7:0], frac};
    end
  end

endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential IEEE-754 single divider with restoring mantissa iteration
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam int DIV_CYCLES = QBITS / BITS_PER_CYCLE;

  fpdiv_state_e      state_q, state_d;
  fp32_t             a_q, a_d, b_q, b_d;
  logic [24:0]       rem_q, rem_d;
  logic [QBITS-1:0]  quot_q, quot_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [31:0]       result_q, result_d;
  logic [3:0]        flags_q, flags_d;

  logic [23:0]       ma, mb;
  logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic [24:0]       rem_t;
  logic [QBITS-1:0]  quot_t;
  logic [31:0]       rn_result;
  logic              rn_overflow, rn_underflow;

  fp_round_norm u_round (
    .sign      (sign_q),
    .exp_in    (exp_q),
    .quot      (quot_q),
    .rem_nz    (rem_q != 25'd0),
    .result    (rn_result),
    .overflow  (rn_overflow),
    .underflow (rn_underflow)
  );

  assign ma     = {1'b1, a_q.frac};
  assign mb     = {1'b1, b_q.frac};
  assign nan_a  = (a_q.exp == 8'hFF) && (a_q.frac != 23'd0);
  assign nan_b  = (b_q.exp == 8'hFF) && (b_q.frac != 23'd0);
  assign inf_a  = (a_q.exp == 8'hFF) && (a_q.frac == 23'd0);
  assign inf_b  = (b_q.exp == 8'hFF) && (b_q.frac == 23'd0);
  assign zero_a = (a_q.exp == 8'h00);
  assign zero_b = (b_q.exp == 8'h00);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;

  // Next-state, operand capture, special-case decode and quotient iteration
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;
    rem_t    = rem_q;
    quot_t   = quot_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          result_d = 32'd0;
          flags_d  = 4'd0;
          state_d  = PREP;
        end
      end
      PREP: begin
        sign_d = a_q.sign ^ b_q.sign;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
          result_d = FP_QNAN;
          flags_d  = 4'b1000;
          state_d  = DONE;
        end else if (zero_b && !inf_a) begin
          result_d = {a_q.sign ^ b_q.sign, FP_INF[30:0]};
          flags_d  = 4'b0100;
          state_d  = DONE;
        end else if (inf_a) begin
          result_d = {a_q.sign ^ b_q.sign, FP_INF[30:0]};
          state_d  = DONE;
        end else if (zero_a || inf_b) begin
          result_d = {a_q.sign ^ b_q.sign, 31'd0};
          state_d  = DONE;
        end else begin
          rem_d   = {1'b0, ma};
          quot_d  = '0;
          exp_d   = {2'b00, a_q.exp} - {2'b00, b_q.exp} + 10'(EXP_BIAS);
          cnt_d   = 5'd0;
          state_d = DIV;
        end
      end
      DIV: begin
        // remainder stays below 2*mb, so 25 bits hold it after the shift
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
          if (rem_t >= {1'b0, mb}) begin
            quot_t = {quot_t[QBITS-2:0], 1'b1};
            rem_t  = rem_t - {1'b0, mb};
          end else begin
            quot_t = {quot_t[QBITS-2:0], 1'b0};
          end
          rem_t = {rem_t[23:0], 1'b0};
        end
        rem_d  = rem_t;
        quot_d = quot_t;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_CYCLES - 1)) begin
          state_d = RND;
        end
      end
      RND: begin
        result_d = rn_result;
        flags_d  = {2'b00, rn_overflow, rn_underflow};
        state_d  = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= 32'd0;
      flags_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule
